regfile_write_arbiter: RTL and testbench

Sole driver of the register file write port (ctrl_writeEnable, ctrl_writeReg, data_writeReg). Merges single-cycle writeback results from the pipeline with results from the multicycle multiply/divide unit. Pipeline writes always win the port. Multdiv results wait in a small queue with WAW squashing, and a per-register pending scoreboard feeds the hazard unit.

---
 rtl/regwb_pkg.sv | 15 +
 rtl/regwb_queue.sv | 91 +++++++++
 rtl/regfile_write_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regwb_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;

  // One queued multdiv result. valid drops when the entry is issued or squashed.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_queue.sv
// Circular buffer of multdiv writeback results.
// Squashed entries keep their slot (valid=0) until they reach the head and are
// popped, so count/full track slots in use, not live results.
module regwb_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  // enqueue at tail
  input  logic                enq_valid,
  input  logic [REG_AW-1:0]   enq_rd,
  input  logic [DATA_W-1:0]   enq_data,
  // pop head (issue or silent drop of a squashed head)
  input  logic                pop,
  // two parallel rd-match squash ports
  input  logic                sq_a_valid,
  input  logic [REG_AW-1:0]   sq_a_rd,
  input  logic                sq_b_valid,
  input  logic [REG_AW-1:0]   sq_b_rd,
  // status
  output wb_entry_t           head,
  output logic                empty,
  output logic                full,
  output logic [NUM_REGS-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         entries_q [DEPTH];
  wb_entry_t         entries_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq_fire;
  logic              pop_fire;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign enq_fire = enq_valid && !full;
  assign pop_fire = pop && !empty;
  assign head     = entries_q[head_q];

  // Next-state: squash, then pop, then enqueue. The new entry is written last
  // so a same-cycle squash on its rd only hits the older copies.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (sq_a_valid && (entries_q[i].rd == sq_a_rd)) entries_d[i].valid = 1'b0;
      if (sq_b_valid && (entries_q[i].rd == sq_b_rd)) entries_d[i].valid = 1'b0;
    end
    if (pop_fire) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PW'(1);
    end
    if (enq_fire) begin
      entries_d[tail_q] = '{valid: 1'b1, rd: enq_rd, data: enq_data};
      tail_d            = tail_q + PW'(1);
    end
    count_d = count_q + CW'(enq_fire) - CW'(pop_fire);
  end

  // Queue state registers.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  // Pending scoreboard: one bit per register with a live queued write.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid) pending[entries_q[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register file write port. Pipeline writebacks always win;
// multdiv results wait in regwb_queue and drain into idle port cycles. A
// starvation counter raises stall_req when the queue head is blocked too long.
module regfile_write_arbiter
  import regwb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                pipe_we,
  input  logic [REG_AW-1:0]   pipe_rd,
  input  logic [DATA_W-1:0]   pipe_data,
  input  logic                md_valid,
  input  logic [REG_AW-1:0]   md_rd,
  input  logic [DATA_W-1:0]   md_data,
  output logic                md_ready,
  output logic                ctrl_writeEnable,
  output logic [REG_AW-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0]   data_writeReg,
  output logic [NUM_REGS-1:0] pending,
  output logic                stall_req
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t         q_head;
  logic              q_empty;
  logic              q_full;
  logic              pipe_slot;
  logic              md_enq;
  logic              head_issue;
  logic              squash_pop;
  logic              pop;

  logic              we_q,    we_d;
  logic [REG_AW-1:0] wreg_q,  wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic              stall_q, stall_d;

  // r0 writes are architecturally dead: they take no port slot and no entry.
  assign pipe_slot  = pipe_we && (pipe_rd != '0);
  assign md_ready   = !q_full && !ctrl_reset;
  assign md_enq     = md_valid && md_ready && (md_rd != '0);
  assign head_issue = !pipe_slot && !q_empty && q_head.valid;
  assign squash_pop = !pipe_slot && !q_empty && !q_head.valid;
  assign pop        = head_issue || squash_pop;

  // Pipe write squashes any older queued copy of its rd; a new md result
  // squashes any older queued copy of its own rd.
  regwb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .enq_valid  (md_enq),
    .enq_rd     (md_rd),
    .enq_data   (md_data),
    .pop        (pop),
    .sq_a_valid (pipe_slot),
    .sq_a_rd    (pipe_rd),
    .sq_b_valid (md_enq),
    .sq_b_rd    (md_rd),
    .head       (q_head),
    .empty      (q_empty),
    .full       (q_full),
    .pending    (pending)
  );

  // Port selection: pipe first, then a live queue head, else idle.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = '0;
    wdata_d = '0;
    if (pipe_slot) begin
      we_d    = 1'b1;
      wreg_d  = pipe_rd;
      wdata_d = pipe_data;
    end else if (head_issue) begin
      we_d    = 1'b1;
      wreg_d  = q_head.rd;
      wdata_d = q_head.data;
    end
  end

  // Starvation counter: counts blocked-head cycles, saturates at the limit.
  // stall_req follows one cycle behind and drops on the edge the head leaves.
  always_comb begin
    starve_d = starve_q;
    if (q_empty || pop) begin
      starve_d = '0;
    end else if (q_head.valid && pipe_slot && (starve_q < SCW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SCW'(1);
    end
    stall_d = !q_empty && !pop && (starve_q >= SCW'(STARVE_LIMIT));
  end

  // Registered port outputs and starvation state.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign stall_req        = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed expectations,
// outputs sampled 1 time unit after each rising edge.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending;
  logic        stall_req;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_write_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .pipe_we          (pipe_we),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pending          (pending),
    .stall_req        (stall_req)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, 32'(ctrl_writeEnable), 32'(we));
    if (we) begin
      chk({tag, "_rd"}, 32'(ctrl_writeReg), 32'(rd));
      chk({tag, "_data"}, data_writeReg, d);
    end
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    pipe_we = we; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    md_valid = v; md_rd = rd; md_data = d;
  endtask

  // Protocol monitor: pipe_we must stay low while stall_req is high.
  always @(negedge clock) begin
    if (!ctrl_reset && pipe_we) chk("proto_stall", 32'(stall_req), 32'd0);
  end

  initial begin
    ctrl_reset = 1'b1;
    pipe(0, 0, 0);
    md(0, 0, 0);
    #1;
    chk("rst_ready", 32'(md_ready), 32'd0);
    tick(); tick();
    port("rst", 0, 0, 0);
    chk("rst_pend", pending, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    ctrl_reset = 1'b0;
    #1;
    chk("rel_ready", 32'(md_ready), 32'd1);

    // idle drain
    md(1, 5, 32'hDEADBEEF);
    tick();
    md(0, 0, 0);
    chk("idle_pend5", pending, 32'h0000_0020);
    port("idle_e0", 0, 0, 0);
    tick();
    port("idle_e1", 1, 5, 32'hDEADBEEF);
    chk("idle_pend_clr", pending, 32'd0);
    tick();
    port("idle_e2", 0, 0, 0);

    // priority
    md(1, 3, 32'h33);
    tick();
    md(0, 0, 0);
    pipe(1, 7, 32'h77);
    tick();
    port("prio_p0", 1, 7, 32'h77);
    chk("prio_pend3", pending, 32'h0000_0008);
    pipe(1, 7, 32'h78);
    tick();
    port("prio_p1", 1, 7, 32'h78);
    pipe(0, 0, 0);
    tick();
    port("prio_md", 1, 3, 32'h33);
    chk("prio_pend_clr", pending, 32'd0);
    tick();
    port("prio_idle", 0, 0, 0);

    // WAW squash
    md(1, 9, 32'h11);
    tick();
    md(0, 0, 0);
    chk("waw_pend9", pending, 32'h0000_0200);
    pipe(1, 9, 32'h22);
    tick();
    port("waw_pipe", 1, 9, 32'h22);
    chk("waw_pend_clr", pending, 32'd0);
    pipe(0, 0, 0);
    tick();
    port("waw_nowr0", 0, 0, 0);
    tick();
    port("waw_nowr1", 0, 0, 0);
    chk("waw_ready", 32'(md_ready), 32'd1);

    // full, then r0 transfer
    for (int i = 0; i < 4; i++) begin
      pipe(1, 1, 32'hA0 + 32'(i));
      md(1, 5'(10 + i), 32'(i));
      tick();
    end
    chk("full_ready", 32'(md_ready), 32'd0);
    chk("full_pend", pending, 32'h0000_3C00);
    port("full_pipe", 1, 1, 32'hA3);
    md(1, 20, 32'h20);
    pipe(1, 1, 32'hA4);
    tick();
    chk("full_noenq_ready", 32'(md_ready), 32'd0);
    chk("full_noenq_pend", pending, 32'h0000_3C00);
    pipe(0, 0, 0);
    tick();
    port("full_pop0", 1, 10, 32'd0);
    chk("full_ready_back", 32'(md_ready), 32'd1);
    chk("full_pend1", pending, 32'h0000_3800);
    md(1, 0, 32'hBAD);
    tick();
    md(0, 0, 0);
    port("full_pop1", 1, 11, 32'd1);
    chk("r0_pend", pending, 32'h0000_3000);
    tick();
    port("full_pop2", 1, 12, 32'd2);
    tick();
    port("full_pop3", 1, 13, 32'd3);
    chk("full_pend_clr", pending, 32'd0);
    tick();
    port("r0_nowr", 0, 0, 0);
    chk("r0_ready", 32'(md_ready), 32'd1);

    // starvation
    md(1, 4, 32'h44);
    tick();
    md(0, 0, 0);
    pipe(1, 2, 32'h2);
    for (int i = 1; i <= 8; i++) tick();
    chk("starve_e8", 32'(stall_req), 32'd0);
    port("starve_pipe", 1, 2, 32'h2);
    tick();
    chk("starve_e9", 32'(stall_req), 32'd1);
    chk("starve_pend4", pending, 32'h0000_0010);
    pipe(0, 0, 0);
    tick();
    port("starve_issue", 1, 4, 32'h44);
    chk("starve_clr", 32'(stall_req), 32'd0);
    chk("starve_pend_clr", pending, 32'd0);
    tick();
    chk("starve_stay_lo", 32'(stall_req), 32'd0);

    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      pipe(1, 1, 32'hC0);
      md(1, 5'(14 + i), 32'hE0 + 32'(i));
      tick();
    end
    md(0, 0, 0);
    pipe(0, 0, 0);
    chk("mid_pend", pending, 32'h0001_C000);
    port("mid_we", 1, 1, 32'hC0);
    #2;
    ctrl_reset = 1'b1;
    #1;
    port("mid_rst", 0, 0, 0);
    chk("mid_rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("mid_rst_data", data_writeReg, 32'd0);
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    chk("mid_rst_ready", 32'(md_ready), 32'd0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(md_ready), 32'd1);
    chk("mid_rel_pend", pending, 32'd0);
    tick();
    port("mid_rel_idle", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
